// File: rtl/axil_native_pkg.sv
// Shared types, response codes and width helpers for the AXI4-Lite to native register bridge.
package axil_native_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Port-select field width; a single port still occupies one address bit.
    function automatic int unsigned psel_w(input int unsigned n_ports);
        return (n_ports <= 1) ? 1 : $clog2(n_ports);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axil_native_timeout.sv
// Loadable down-counter; expire_c_o flags the last enabled cycle before the count runs out.
module axil_native_timeout #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_c_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A load value of zero parks the counter at zero, so it never expires.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/axil_native_bridge.sv
// AXI4-Lite slave that serves one transaction at a time onto NUM_PORTS native register ports,
// with alternating read/write priority, byte enables, an access timeout and error responses.
module axil_native_bridge
    import axil_native_pkg::*;
#(
    parameter int unsigned S_AXI_ADDR_WIDTH  = 12,
    parameter int unsigned S_AXI_DATA_WIDTH  = 32,
    parameter int unsigned NATIVE_ADDR_WIDTH = 8,
    parameter int unsigned NATIVE_DATA_WIDTH = 32,
    parameter int unsigned NUM_PORTS         = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic                                   S_AXI_aclk,
    input  logic                                   S_AXI_aresetn,
    input  logic [S_AXI_ADDR_WIDTH-1:0]            S_AXI_awaddr,
    input  logic [2:0]                             S_AXI_awprot,
    input  logic                                   S_AXI_awvalid,
    output logic                                   S_AXI_awready,
    input  logic [S_AXI_DATA_WIDTH-1:0]            S_AXI_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0]          S_AXI_wstrb,
    input  logic                                   S_AXI_wvalid,
    output logic                                   S_AXI_wready,
    output logic [1:0]                             S_AXI_bresp,
    output logic                                   S_AXI_bvalid,
    input  logic                                   S_AXI_bready,
    input  logic [S_AXI_ADDR_WIDTH-1:0]            S_AXI_araddr,
    input  logic [2:0]                             S_AXI_arprot,
    input  logic                                   S_AXI_arvalid,
    output logic                                   S_AXI_arready,
    output logic [S_AXI_DATA_WIDTH-1:0]            S_AXI_rdata,
    output logic [1:0]                             S_AXI_rresp,
    output logic                                   S_AXI_rvalid,
    input  logic                                   S_AXI_rready,
    output logic                                   NATIVE_CLK,
    output logic [NUM_PORTS-1:0]                   NATIVE_EN,
    output logic                                   NATIVE_WR,
    output logic [NATIVE_ADDR_WIDTH-1:0]           NATIVE_ADDR,
    output logic [NATIVE_DATA_WIDTH/8-1:0]         NATIVE_BE,
    output logic [NATIVE_DATA_WIDTH-1:0]           NATIVE_DATA_IN,
    input  logic [NUM_PORTS*NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
    input  logic [NUM_PORTS-1:0]                   NATIVE_READY
);

    localparam int unsigned PSEL_W = psel_w(NUM_PORTS);
    localparam int unsigned NPAD   = 1 << PSEL_W;
    localparam int unsigned NAW    = NATIVE_ADDR_WIDTH;
    localparam int unsigned NDW    = NATIVE_DATA_WIDTH;
    localparam int unsigned NBE    = NATIVE_DATA_WIDTH / 8;
    localparam int unsigned SDW    = S_AXI_DATA_WIDTH;
    localparam int unsigned CNT_W  = cnt_w(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              last_wr_q, last_wr_d;
    logic [PSEL_W-1:0] port_q, port_d;
    logic [1:0]        resp_q, resp_d;

    logic              awready_q, awready_d;
    logic              arready_q, arready_d;
    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;
    logic [SDW-1:0]    rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] en_q, en_d;
    logic              nwr_q, nwr_d;
    logic [NAW-1:0]    naddr_q, naddr_d;
    logic [NBE-1:0]    be_q, be_d;
    logic [NDW-1:0]    din_q, din_d;

    logic                        wr_pend, rd_pend;
    logic [S_AXI_ADDR_WIDTH-1:0] acc_addr;
    logic [PSEL_W-1:0]           dec_port;
    logic                        dec_err;
    logic [NPAD-1:0]             ready_ext;
    logic                        ready_sel;
    logic [NDW-1:0]              rd_sel;
    logic                        timeout_load, timeout_en, timeout_expire;
    logic                        unused_ok;

    assign wr_pend   = S_AXI_awvalid && S_AXI_wvalid;
    assign rd_pend   = S_AXI_arvalid;
    assign acc_addr  = wr_q ? S_AXI_awaddr : S_AXI_araddr;
    assign dec_port  = acc_addr[NAW+PSEL_W+1:NAW+2];
    assign dec_err   = 32'(dec_port) >= 32'(NUM_PORTS);
    assign ready_ext = NPAD'(NATIVE_READY);
    assign ready_sel = ready_ext[port_q];
    assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr, S_AXI_araddr,
                         S_AXI_wdata, S_AXI_wstrb};

    // Read data of the port being served
    always_comb begin
        rd_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_q == PSEL_W'(p)) begin
                rd_sel = NATIVE_DATA_OUT[p*NDW +: NDW];
            end
        end
    end

    axil_native_timeout #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk_i      (S_AXI_aclk),
        .rst_ni     (S_AXI_aresetn),
        .load_i     (timeout_load),
        .load_val_i (CNT_W'(TIMEOUT_CYCLES)),
        .en_i       (timeout_en),
        .expire_c_o (timeout_expire)
    );

    always_ff @(posedge S_AXI_aclk) begin
        if (!S_AXI_aresetn) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            last_wr_q <= 1'b0;
            port_q    <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            last_wr_q <= last_wr_d;
            port_q    <= port_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        last_wr_d    = last_wr_q;
        port_d       = port_q;
        resp_d       = resp_q;
        timeout_load = 1'b0;
        timeout_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the type not served last wins
                if (wr_pend || rd_pend) begin
                    state_d = ST_ACCEPT;
                    wr_d    = wr_pend && (!rd_pend || !last_wr_q);
                end
            end
            ST_ACCEPT: begin
                port_d = dec_port;
                if (dec_err) begin
                    state_d = ST_RESP;
                    resp_d  = RESP_DECERR;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                timeout_load = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                timeout_en = !ready_sel;
                if (ready_sel) begin
                    state_d = ST_RESP;
                    resp_d  = RESP_OKAY;
                end else if (timeout_expire) begin
                    state_d = ST_RESP;
                    resp_d  = RESP_SLVERR;
                end
            end
            ST_RESP: begin
                if ((wr_q && bvalid_q && S_AXI_bready) || (!wr_q && rvalid_q && S_AXI_rready)) begin
                    state_d   = ST_IDLE;
                    last_wr_d = wr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values are keyed on the next state so every port is driven from a flop
    always_comb begin
        awready_d = (state_d == ST_ACCEPT) && wr_d;
        arready_d = (state_d == ST_ACCEPT) && !wr_d;
        bvalid_d  = (state_d == ST_RESP) && wr_d;
        rvalid_d  = (state_d == ST_RESP) && !wr_d;
        en_d      = '0;
        nwr_d     = nwr_q;
        naddr_d   = naddr_q;
        be_d      = be_q;
        din_d     = din_q;
        rdata_d   = rdata_q;
        if (state_q == ST_ACCEPT) begin
            naddr_d = acc_addr[NAW+1:2];
            be_d    = wr_q ? S_AXI_wstrb[NBE-1:0] : '0;
            din_d   = wr_q ? S_AXI_wdata[NDW-1:0] : '0;
            rdata_d = '0;
        end
        if (state_d == ST_ACCESS) begin
            nwr_d = wr_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                en_d[p] = (dec_port == PSEL_W'(p));
            end
        end
        if (state_d == ST_IDLE) begin
            nwr_d = 1'b0;
        end
        if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
            rdata_d = (ready_sel && !wr_q) ? SDW'(rd_sel) : '0;
        end
    end

    always_ff @(posedge S_AXI_aclk) begin
        if (!S_AXI_aresetn) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= '0;
            nwr_q     <= 1'b0;
            naddr_q   <= '0;
            be_q      <= '0;
            din_q     <= '0;
        end else begin
            awready_q <= awready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            nwr_q     <= nwr_d;
            naddr_q   <= naddr_d;
            be_q      <= be_d;
            din_q     <= din_d;
        end
    end

    assign S_AXI_awready  = awready_q;
    assign S_AXI_wready   = awready_q;
    assign S_AXI_arready  = arready_q;
    assign S_AXI_bvalid   = bvalid_q;
    assign S_AXI_bresp    = resp_q;
    assign S_AXI_rvalid   = rvalid_q;
    assign S_AXI_rresp    = resp_q;
    assign S_AXI_rdata    = rdata_q;
    assign NATIVE_CLK     = S_AXI_aclk;
    assign NATIVE_EN      = en_q;
    assign NATIVE_WR      = nwr_q;
    assign NATIVE_ADDR    = naddr_q;
    assign NATIVE_BE      = be_q;
    assign NATIVE_DATA_IN = din_q;

endmodule

// File: tb/tb_axil_native_bridge.sv
// Directed bench: dut_a uses default parameters, dut_b has 3 ports and a 4-cycle timeout.
module tb_axil_native_bridge;

    logic         clk;
    logic         rstn;
    logic [11:0]  awaddr, araddr;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awvalid_a, wvalid_a, arvalid_a;
    logic         awvalid_b, wvalid_b, arvalid_b;
    logic         bready, rready;
    logic [127:0] dout;
    logic [3:0]   ready;

    logic        awready_a, wready_a, arready_a, bvalid_a, rvalid_a, nclk_a, wr_a;
    logic [1:0]  bresp_a, rresp_a;
    logic [31:0] rdata_a, din_a;
    logic [3:0]  en_a, be_a;
    logic [7:0]  addr_a;

    logic        awready_b, wready_b, arready_b, bvalid_b, rvalid_b, nclk_b, wr_b;
    logic [1:0]  bresp_b, rresp_b;
    logic [31:0] rdata_b, din_b;
    logic [2:0]  en_b;
    logic [3:0]  be_b;
    logic [7:0]  addr_b;

    int n_cmp = 0;
    int n_err = 0;
    int n_resp;
    logic [3:0] order;

    axil_native_bridge dut_a (
        .S_AXI_aclk(clk), .S_AXI_aresetn(rstn),
        .S_AXI_awaddr(awaddr), .S_AXI_awprot(3'b000), .S_AXI_awvalid(awvalid_a), .S_AXI_awready(awready_a),
        .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid_a), .S_AXI_wready(wready_a),
        .S_AXI_bresp(bresp_a), .S_AXI_bvalid(bvalid_a), .S_AXI_bready(bready),
        .S_AXI_araddr(araddr), .S_AXI_arprot(3'b000), .S_AXI_arvalid(arvalid_a), .S_AXI_arready(arready_a),
        .S_AXI_rdata(rdata_a), .S_AXI_rresp(rresp_a), .S_AXI_rvalid(rvalid_a), .S_AXI_rready(rready),
        .NATIVE_CLK(nclk_a), .NATIVE_EN(en_a), .NATIVE_WR(wr_a), .NATIVE_ADDR(addr_a),
        .NATIVE_BE(be_a), .NATIVE_DATA_IN(din_a), .NATIVE_DATA_OUT(dout), .NATIVE_READY(ready)
    );

    axil_native_bridge #(.NUM_PORTS(3), .TIMEOUT_CYCLES(4)) dut_b (
        .S_AXI_aclk(clk), .S_AXI_aresetn(rstn),
        .S_AXI_awaddr(awaddr), .S_AXI_awprot(3'b000), .S_AXI_awvalid(awvalid_b), .S_AXI_awready(awready_b),
        .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid_b), .S_AXI_wready(wready_b),
        .S_AXI_bresp(bresp_b), .S_AXI_bvalid(bvalid_b), .S_AXI_bready(bready),
        .S_AXI_araddr(araddr), .S_AXI_arprot(3'b000), .S_AXI_arvalid(arvalid_b), .S_AXI_arready(arready_b),
        .S_AXI_rdata(rdata_b), .S_AXI_rresp(rresp_b), .S_AXI_rvalid(rvalid_b), .S_AXI_rready(rready),
        .NATIVE_CLK(nclk_b), .NATIVE_EN(en_b), .NATIVE_WR(wr_b), .NATIVE_ADDR(addr_b),
        .NATIVE_BE(be_b), .NATIVE_DATA_IN(din_b), .NATIVE_DATA_OUT(dout[95:0]), .NATIVE_READY(ready[2:0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid_a = 0; wvalid_a = 0; arvalid_a = 0;
        awvalid_b = 0; wvalid_b = 0; arvalid_b = 0;
        bready = 0; rready = 1; dout = '0; ready = '0;
        repeat (3) tick();

        // Reset state
        chk("reset_a", 128'({awready_a, wready_a, arready_a, bvalid_a, rvalid_a, bresp_a, rresp_a,
                             rdata_a, en_a, wr_a, addr_a, be_a, din_a}), 128'(0));
        chk("reset_b", 128'({awready_b, arready_b, bvalid_b, rvalid_b, en_b, wr_b, rdata_b}), 128'(0));
        chk("native_clk", 128'(nclk_a), 128'(clk));
        rstn = 1'b1;
        tick();

        // Write 0xA5A50001 to 0x004: port 0, word 1
        awaddr = 12'h004; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        awvalid_a = 1; wvalid_a = 1;
        tick();
        chk("wr1_c1_ready", 128'({awready_a, wready_a, |en_a}), 128'(3'b110));
        tick();
        awvalid_a = 0; wvalid_a = 0;
        chk("wr1_c2_native", 128'({awready_a, en_a, wr_a, addr_a, be_a, din_a}),
            128'({1'b0, 4'b0001, 1'b1, 8'h01, 4'hF, 32'hA5A5_0001}));
        tick();
        chk("wr1_c3_strobe", 128'({en_a, bvalid_a}), 128'(0));
        ready = 4'b0001;
        tick();
        ready = 4'b0000;
        chk("wr1_c4_resp", 128'({bvalid_a, bresp_a}), 128'(3'b100));
        tick();
        chk("wr1_bvalid_hold", 128'({bvalid_a, wr_a}), 128'(2'b11));
        bready = 1;
        tick();
        chk("wr1_done", 128'({bvalid_a, wr_a}), 128'(0));

        // Read 0x808: port 2, word 2; READY after five WAIT cycles, other ports' READY ignored
        araddr = 12'h808;
        dout[31:0] = 32'hDEAD_0000; dout[95:64] = 32'h0000_1234;
        arvalid_a = 1;
        tick();
        chk("rd2_c1_arready", 128'({arready_a, awready_a}), 128'(2'b10));
        tick();
        arvalid_a = 0;
        chk("rd2_c2_native", 128'({en_a, wr_a, addr_a}), 128'({4'b0100, 1'b0, 8'h02}));
        ready = 4'b1011;
        for (int i = 3; i <= 7; i++) begin
            tick();
            chk($sformatf("rd2_wait_c%0d", i), 128'(rvalid_a), 128'(0));
        end
        tick();
        ready = 4'b0100;
        tick();
        ready = 4'b0000;
        chk("rd2_c9_resp", 128'({rvalid_a, rresp_a, rdata_a}), 128'({1'b1, 2'b00, 32'h0000_1234}));
        tick();
        chk("rd2_done", 128'(rvalid_a), 128'(0));

        // dut_b: read 0x400 (port 1) with READY low times out after four WAIT cycles
        araddr = 12'h400; dout[63:32] = 32'h0000_BEEF;
        arvalid_b = 1;
        tick();
        chk("to_c1_arready", 128'(arready_b), 128'(1));
        tick();
        arvalid_b = 0;
        chk("to_c2_en", 128'(en_b), 128'(3'b010));
        for (int i = 3; i <= 6; i++) begin
            tick();
            chk($sformatf("to_wait_c%0d", i), 128'(rvalid_b), 128'(0));
        end
        rready = 0;
        tick();
        chk("to_c7_slverr", 128'({rvalid_b, rresp_b, rdata_b}), 128'({1'b1, 2'b10, 32'h0}));
        ready = 4'hF;
        tick();
        chk("to_late_ready", 128'({rvalid_b, rresp_b, rdata_b}), 128'({1'b1, 2'b10, 32'h0}));
        rready = 1; ready = 4'h0;
        tick();
        chk("to_done", 128'(rvalid_b), 128'(0));

        // dut_b: write to 0xC00 decodes to port 3, which does not exist
        awaddr = 12'hC00; wdata = 32'h1111_2222; wstrb = 4'hF;
        awvalid_b = 1; wvalid_b = 1;
        tick();
        chk("dec_c1_ready", 128'({awready_b, wready_b}), 128'(2'b11));
        tick();
        awvalid_b = 0; wvalid_b = 0;
        chk("dec_c2_resp", 128'({bvalid_b, bresp_b, en_b}), 128'({1'b1, 2'b11, 3'b000}));
        tick();
        chk("dec_done", 128'({bvalid_b, en_b}), 128'(0));

        // dut_a: write and read requested together continuously alternate, write first
        awaddr = 12'h010; wdata = 32'h0000_00FF; wstrb = 4'h3;
        araddr = 12'h404; dout[63:32] = 32'h0000_5555;
        ready = 4'hF;
        awvalid_a = 1; wvalid_a = 1; arvalid_a = 1;
        n_resp = 0; order = '0;
        for (int i = 0; i < 60 && n_resp < 4; i++) begin
            tick();
            if ((|en_a) && wr_a) chk("tie_be", 128'({be_a, addr_a}), 128'({4'h3, 8'h04}));
            if (bvalid_a || rvalid_a) begin
                order = {order[2:0], bvalid_a};
                n_resp++;
                if (rvalid_a) chk("tie_rdata", 128'(rdata_a), 128'(32'h0000_5555));
            end
        end
        awvalid_a = 0; wvalid_a = 0; arvalid_a = 0;
        ready = 4'h0;
        chk("tie_count", 128'(n_resp), 128'(4));
        chk("tie_order", 128'(order), 128'(4'b1010));
        repeat (2) tick();

        // Reset asserted while waiting on READY, then a normal read
        araddr = 12'h808;
        arvalid_a = 1;
        tick();
        tick();
        arvalid_a = 0;
        tick();
        rstn = 0;
        tick();
        chk("rst_mid_wait", 128'({awready_a, wready_a, arready_a, bvalid_a, rvalid_a, bresp_a, rresp_a,
                                  rdata_a, en_a, wr_a, addr_a, be_a, din_a}), 128'(0));
        rstn = 1;
        tick();
        araddr = 12'h00C; dout[31:0] = 32'hCAFE_0003;
        arvalid_a = 1;
        tick();
        chk("post_rst_arready", 128'(arready_a), 128'(1));
        tick();
        arvalid_a = 0;
        chk("post_rst_native", 128'({en_a, wr_a, addr_a}), 128'({4'b0001, 1'b0, 8'h03}));
        tick();
        ready = 4'b0001;
        tick();
        ready = 4'b0000;
        chk("post_rst_resp", 128'({rvalid_a, rresp_a, rdata_a}), 128'({1'b1, 2'b00, 32'hCAFE_0003}));
        tick();
        chk("post_rst_done", 128'(rvalid_a), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
